// File: rtl/dbg_mem_arbiter.sv
// -----------------------------------------------------------------------------
// dbg_mem_arbiter
//
// Shares the single port of one synchronous SRAM (imem or dmem) between the
// CPU core and the debug controller. A debug request arrives as a one-cycle
// strobe. It is held pending and issued when the core leaves the port idle.
// If the core has kept the port busy for STARVE_LIMIT pending cycles, the
// request is issued anyway and the core is stalled for that one cycle. Debug
// read data is captured into a held register.
//
// Ports
//   cpu_clk, cpu_rstn        clock, asynchronous active-low reset
//   dbg_addr/wdata/we/ce     debug request, sampled while dbg_ce=1
//   dbg_rdata                last completed debug read data, held
//   dbg_busy                 debug request in flight (state != IDLE)
//   dbg_overrun              sticky, a dbg_ce arrived while busy
//   core_addr/wdata/ce/we    core request
//   core_rdata               combinational copy of mem_rdata
//   core_stall               core request not issued this cycle, must be held
//   mem_addr/wdata/ce/we     SRAM port
//   mem_rdata                SRAM read data, valid the cycle after a read
//   fsm_state                current arbiter state, for observation
//
// Handshake: dbg_ce is a fire-and-forget strobe that is accepted only while
// dbg_busy=0. A strobe that arrives while busy is dropped and sets
// dbg_overrun. core_ce is a request that counts as issued in every cycle where
// core_stall=0. While core_stall=1 the core must hold core_* unchanged.
// -----------------------------------------------------------------------------
module dbg_mem_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  cpu_clk,
   input  logic                  cpu_rstn,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   input  logic [DATA_WIDTH-1:0] dbg_wdata,
   input  logic                  dbg_ce,
   input  logic                  dbg_we,
   output logic [DATA_WIDTH-1:0] dbg_rdata,
   output logic                  dbg_busy,
   output logic                  dbg_overrun,
   input  logic [ADDR_WIDTH-1:0] core_addr,
   input  logic [DATA_WIDTH-1:0] core_wdata,
   input  logic                  core_ce,
   input  logic                  core_we,
   output logic [DATA_WIDTH-1:0] core_rdata,
   output logic                  core_stall,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_ce,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [1:0]            fsm_state
);

   // With STARVE_LIMIT=0, clog2(1)=0, so keep at least one counter bit.
   localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_PEND   = 2'd1;
   localparam logic [1:0] ST_RDWAIT = 2'd2;

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic [ADDR_WIDTH-1:0] pend_addr;
   logic [DATA_WIDTH-1:0] pend_wdata;
   logic                  pend_we;
   logic [CNT_W-1:0]      starve_cnt;
   logic                  grant;
   logic                  accept;

   // Debug owns the port when the core is idle, or once the wait is exhausted.
   assign grant  = (state == ST_PEND) && (!core_ce || (starve_cnt == CNT_MAX));
   assign accept = (state == ST_IDLE) && dbg_ce;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (dbg_ce) state_nxt = ST_PEND;
         ST_PEND:   if (grant)  state_nxt = pend_we ? ST_IDLE : ST_RDWAIT;
         ST_RDWAIT: state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         pend_addr  <= '0;
         pend_wdata <= '0;
         pend_we    <= 1'b0;
         starve_cnt <= '0;
      end else begin
         if (accept) begin
            pend_addr  <= dbg_addr;
            pend_wdata <= dbg_wdata;
            pend_we    <= dbg_we;
            starve_cnt <= '0;
         end else if ((state == ST_PEND) && !grant) begin
            // Never passes CNT_MAX: reaching it forces a grant.
            starve_cnt <= starve_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         dbg_rdata   <= '0;
         dbg_overrun <= 1'b0;
      end else begin
         // The SRAM returns the debug read one cycle after the grant.
         if (state == ST_RDWAIT) begin
            dbg_rdata <= mem_rdata;
         end
         if (dbg_ce && (state != ST_IDLE)) begin
            dbg_overrun <= 1'b1;
         end
      end
   end

   assign mem_addr   = grant ? pend_addr  : core_addr;
   assign mem_wdata  = grant ? pend_wdata : core_wdata;
   assign mem_ce     = grant ? 1'b1       : core_ce;
   assign mem_we     = grant ? pend_we    : core_we;

   assign core_stall = grant && core_ce;
   assign core_rdata = mem_rdata;
   assign dbg_busy   = (state != ST_IDLE);
   assign fsm_state  = state;

endmodule

// File: tb/tb_dbg_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dbg_mem_arbiter
//
// Two arbiters share one set of stimulus: u_dut4 (STARVE_LIMIT=4) and u_dut0
// (STARVE_LIMIT=0). Each one has its own behavioural SRAM. The SRAM output
// holds its value when there is no read access. Inputs are driven 1 time unit
// after the rising edge, and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dbg_mem_arbiter;

   // ---------------- clock / reset ----------------
   logic cpu_clk = 1'b0;
   logic cpu_rstn = 1'b0;
   always #5 cpu_clk = ~cpu_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   // ---------------- shared stimulus ----------------
   logic [31:0] dbg_addr = '0, dbg_wdata = '0;
   logic        dbg_ce = 1'b0, dbg_we = 1'b0;
   logic [31:0] core_addr = '0, core_wdata = '0;
   logic        core_ce = 1'b0, core_we = 1'b0;

   // ---------------- DUT with STARVE_LIMIT=4 ----------------
   logic [31:0] dbg_rdata, core_rdata, mem_addr, mem_wdata;
   logic        dbg_busy, dbg_overrun, core_stall, mem_ce, mem_we;
   logic [1:0]  fsm_state;
   logic [31:0] m4_rdata = '0;
   logic [31:0] m4_data [0:255];
   logic [255:0] m4_wv = '0;

   dbg_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) u_dut4 (
      .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
      .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ce(dbg_ce), .dbg_we(dbg_we),
      .dbg_rdata(dbg_rdata), .dbg_busy(dbg_busy), .dbg_overrun(dbg_overrun),
      .core_addr(core_addr), .core_wdata(core_wdata), .core_ce(core_ce), .core_we(core_we),
      .core_rdata(core_rdata), .core_stall(core_stall),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ce(mem_ce), .mem_we(mem_we),
      .mem_rdata(m4_rdata), .fsm_state(fsm_state)
   );

   // ---------------- DUT with STARVE_LIMIT=0 ----------------
   logic [31:0] z_dbg_rdata, z_core_rdata, z_mem_addr, z_mem_wdata;
   logic        z_dbg_busy, z_dbg_overrun, z_core_stall, z_mem_ce, z_mem_we;
   logic [1:0]  z_fsm_state;
   logic [31:0] m0_rdata = '0;
   logic [31:0] m0_data [0:255];
   logic [255:0] m0_wv = '0;

   dbg_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(0)) u_dut0 (
      .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
      .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ce(dbg_ce), .dbg_we(dbg_we),
      .dbg_rdata(z_dbg_rdata), .dbg_busy(z_dbg_busy), .dbg_overrun(z_dbg_overrun),
      .core_addr(core_addr), .core_wdata(core_wdata), .core_ce(core_ce), .core_we(core_we),
      .core_rdata(z_core_rdata), .core_stall(z_core_stall),
      .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata), .mem_ce(z_mem_ce), .mem_we(z_mem_we),
      .mem_rdata(m0_rdata), .fsm_state(z_fsm_state)
   );

   // ---------------- SRAM models ----------------
   function automatic logic [31:0] init_val(input logic [7:0] a);
      case (a)
         8'h10:   return 32'hDEADBEEF;
         8'h40:   return 32'hCAFE0040;
         default: return {24'hA5A5A5, a};
      endcase
   endfunction

   always @(posedge cpu_clk) begin
      if (mem_ce) begin
         if (mem_we) begin
            m4_data[mem_addr[7:0]] <= mem_wdata;
            m4_wv[mem_addr[7:0]]   <= 1'b1;
         end else begin
            m4_rdata <= m4_wv[mem_addr[7:0]] ? m4_data[mem_addr[7:0]] : init_val(mem_addr[7:0]);
         end
      end
   end

   always @(posedge cpu_clk) begin
      if (z_mem_ce) begin
         if (z_mem_we) begin
            m0_data[z_mem_addr[7:0]] <= z_mem_wdata;
            m0_wv[z_mem_addr[7:0]]   <= 1'b1;
         end else begin
            m0_rdata <= m0_wv[z_mem_addr[7:0]] ? m0_data[z_mem_addr[7:0]] : init_val(z_mem_addr[7:0]);
         end
      end
   end

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] last_rd = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic next_cycle();
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) next_cycle();
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
   } dbg_vec_t;

   // One debug access with the core idle, checked cycle by cycle from T.
   task automatic dbg_op(input dbg_vec_t v);
      dbg_ce = 1'b1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata;
      @(negedge cpu_clk);
      check("op_busy_T", 32'(dbg_busy), 32'd0);
      next_cycle();
      dbg_ce = 1'b0;
      @(negedge cpu_clk);
      check("op_mem_ce_T1", 32'(mem_ce), 32'd1);
      check("op_mem_we_T1", 32'(mem_we), 32'(v.we));
      check("op_mem_addr_T1", mem_addr, v.addr);
      check("op_stall_T1", 32'(core_stall), 32'd0);
      check("op_busy_T1", 32'(dbg_busy), 32'd1);
      if (v.we) check("op_mem_wdata_T1", mem_wdata, v.wdata);
      next_cycle();
      @(negedge cpu_clk);
      if (v.we) begin
         check("wr_busy_T2", 32'(dbg_busy), 32'd0);
         check("wr_rdata_kept", dbg_rdata, v.exp_rdata);
      end else begin
         check("rd_busy_T2", 32'(dbg_busy), 32'd1);
         check("rd_rdata_T2_old", dbg_rdata, last_rd);
         next_cycle();
         @(negedge cpu_clk);
         check("rd_busy_T3", 32'(dbg_busy), 32'd0);
         check("rd_rdata_T3", dbg_rdata, v.exp_rdata);
      end
      last_rd = v.exp_rdata;
      next_cycle();
   endtask

   dbg_vec_t vecs [6];

   // ---------------- test sequence ----------------
   initial begin
      vecs[0] = '{1'b0, 32'h10, 32'h0,         32'hDEADBEEF};
      vecs[1] = '{1'b1, 32'h20, 32'h12345678,  32'hDEADBEEF};
      vecs[2] = '{1'b0, 32'h20, 32'h0,         32'h12345678};
      vecs[3] = '{1'b1, 32'h30, 32'hA1B2C3D4,  32'h12345678};
      vecs[4] = '{1'b0, 32'h30, 32'h0,         32'hA1B2C3D4};
      vecs[5] = '{1'b0, 32'h55, 32'h0,         32'hA5A5A555};

      // Reset: mem_* mirrors the core, outputs at reset values.
      core_ce = 1'b1; core_we = 1'b1; core_addr = 32'h33; core_wdata = 32'h5555AAAA;
      @(negedge cpu_clk);
      check("rst_mem_addr", mem_addr, 32'h33);
      check("rst_mem_wdata", mem_wdata, 32'h5555AAAA);
      check("rst_mem_ce", 32'(mem_ce), 32'd1);
      check("rst_mem_we", 32'(mem_we), 32'd1);
      check("rst_stall", 32'(core_stall), 32'd0);
      check("rst_busy", 32'(dbg_busy), 32'd0);
      check("rst_overrun", 32'(dbg_overrun), 32'd0);
      check("rst_rdata", dbg_rdata, 32'd0);
      cpu_rstn = 1'b1;
      next_cycle();
      core_ce = 1'b0; core_we = 1'b0;
      idle_cycles(2);

      // Table of debug accesses with the core idle.
      for (int i = 0; i < 6; i++) begin
         dbg_op(vecs[i]);
      end
      idle_cycles(2);

      // Core busy every cycle: grant at T+5, one stall, held access at T+6.
      begin
         int          issued;
         logic        exp_stall;
         logic [31:0] exp_caddr;
         issued = 0;
         for (int k = 0; k < 8; k++) begin
            dbg_ce = (k == 0); dbg_we = 1'b0; dbg_addr = 32'h10;
            core_ce = 1'b1; core_we = 1'b0; core_addr = 32'h80 + 32'(issued);
            exp_stall = (k == 5);
            exp_caddr = (k <= 5) ? 32'h80 + 32'(k) : 32'h80 + 32'(k - 1);
            @(negedge cpu_clk);
            check("starve_stall", 32'(core_stall), 32'(exp_stall));
            check("starve_mem_ce", 32'(mem_ce), 32'd1);
            check("starve_mem_addr", mem_addr, exp_stall ? 32'h10 : exp_caddr);
            if (k == 5) check("starve_grant_we", 32'(mem_we), 32'd0);
            if (k == 6) check("starve_busy_T6", 32'(dbg_busy), 32'd1);
            if (k == 7) begin
               check("starve_busy_T7", 32'(dbg_busy), 32'd0);
               check("starve_rdata_T7", dbg_rdata, 32'hDEADBEEF);
            end
            if (!core_stall) issued++;
            next_cycle();
         end
         core_ce = 1'b0;
         idle_cycles(3);
      end

      // Overrun: second strobe at T+1 is dropped and flagged.
      dbg_ce = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
      @(negedge cpu_clk);
      check("ovr_before", 32'(dbg_overrun), 32'd0);
      next_cycle();
      dbg_ce = 1'b1; dbg_addr = 32'h30;
      @(negedge cpu_clk);
      check("ovr_grant_addr", mem_addr, 32'h20);
      next_cycle();
      dbg_ce = 1'b0;
      @(negedge cpu_clk);
      check("ovr_set", 32'(dbg_overrun), 32'd1);
      next_cycle();
      @(negedge cpu_clk);
      check("ovr_rdata_first", dbg_rdata, 32'h12345678);
      check("ovr_no_second", 32'(dbg_busy), 32'd0);
      idle_cycles(4);
      @(negedge cpu_clk);
      check("ovr_sticky", 32'(dbg_overrun), 32'd1);
      next_cycle();

      // Reset while PEND with the core active.
      core_ce = 1'b1; core_we = 1'b0; core_addr = 32'h90;
      dbg_ce = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
      next_cycle();
      dbg_ce = 1'b0;
      @(negedge cpu_clk);
      check("pend_busy", 32'(dbg_busy), 32'd1);
      check("pend_stall", 32'(core_stall), 32'd0);
      #2;
      cpu_rstn = 1'b0;
      #1;
      check("arst_busy", 32'(dbg_busy), 32'd0);
      check("arst_stall", 32'(core_stall), 32'd0);
      check("arst_overrun", 32'(dbg_overrun), 32'd0);
      check("arst_rdata", dbg_rdata, 32'd0);
      check("arst_mem_addr", mem_addr, 32'h90);
      next_cycle();
      @(negedge cpu_clk);
      cpu_rstn = 1'b1;
      for (int i = 0; i < 7; i++) begin
         next_cycle();
         core_addr = 32'h90 + 32'(i);
         @(negedge cpu_clk);
         check("post_rst_mem_addr", mem_addr, 32'h90 + 32'(i));
         check("post_rst_mem_ce", 32'(mem_ce), 32'd1);
         check("post_rst_stall", 32'(core_stall), 32'd0);
         check("post_rst_busy", 32'(dbg_busy), 32'd0);
      end
      next_cycle();
      core_ce = 1'b0;
      idle_cycles(3);

      // STARVE_LIMIT=0: core read 0x40 at T-1, debug read at T, core read at T+1.
      core_ce = 1'b1; core_we = 1'b0; core_addr = 32'h40;
      next_cycle();
      core_ce = 1'b0;
      dbg_ce = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
      @(negedge cpu_clk);
      check("s0_core_rdata_T", z_core_rdata, 32'hCAFE0040);
      check("s0_busy_T", 32'(z_dbg_busy), 32'd0);
      next_cycle();
      dbg_ce = 1'b0;
      core_ce = 1'b1; core_addr = 32'h44;
      @(negedge cpu_clk);
      check("s0_core_rdata_T1", z_core_rdata, 32'hCAFE0040);
      check("s0_stall_T1", 32'(z_core_stall), 32'd1);
      check("s0_mem_addr_T1", z_mem_addr, 32'h10);
      check("s0_mem_ce_T1", 32'(z_mem_ce), 32'd1);
      check("s0_mem_we_T1", 32'(z_mem_we), 32'd0);
      next_cycle();
      @(negedge cpu_clk);
      check("s0_stall_T2", 32'(z_core_stall), 32'd0);
      check("s0_mem_addr_T2", z_mem_addr, 32'h44);
      check("s0_busy_T2", 32'(z_dbg_busy), 32'd1);
      next_cycle();
      core_ce = 1'b0;
      @(negedge cpu_clk);
      check("s0_rdata_T3", z_dbg_rdata, 32'hDEADBEEF);
      check("s0_core_rdata_T3", z_core_rdata, 32'hA5A5A544);
      check("s0_busy_T3", 32'(z_dbg_busy), 32'd0);
      idle_cycles(8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
